// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared FSM state type and line/parity constants for the UART TX FIFO reader.
package uart_tx_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = ~PAR_EVEN;
    localparam logic LINE_IDLE = 1'b1;
endpackage

// File: rtl/uart_tx_bit_timer.sv
// uart_tx_bit_timer: prescale counter that pulses bit_done_o on the last cycle of each UART bit.
//   CLK, RST    clock and synchronous active-high reset
//   clear_i     hold the counter at zero (used while idle)
//   presc_i     cycles per bit, already forced to at least 1
//   bit_done_o  high for one cycle when the counter reaches presc_i-1
module uart_tx_bit_timer #(
    parameter int PRESC_WIDTH = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   clear_i,
    input  logic [PRESC_WIDTH-1:0] presc_i,
    output logic                   bit_done_o
);
    logic [PRESC_WIDTH-1:0] cnt_q, cnt_d;
    assign bit_done_o = cnt_q == presc_i - PRESC_WIDTH'(1);
    assign cnt_d = (clear_i || bit_done_o) ? '0 : cnt_q + PRESC_WIDTH'(1);
    always_ff @(posedge CLK) cnt_q <= RST ? '0 : cnt_d;
endmodule

// File: rtl/uart_fifo_tx.sv
// uart_fifo_tx: pops bytes from the TX async FIFO read port and serializes them as UART frames.
//   CLK, RST      FIFO read-domain clock, synchronous active-high reset
//   PRESCALE      cycles per bit (0 acts as 1), PAR_EN/PAR_TYP parity enable / odd select
//   FIFO_EMPTY, FIFO_RD_DATA  fall-through FIFO head; FIFO_R_INC one-cycle pop strobe
//   TX_OUT        registered serial line, idle high; BUSY high while a frame is on the line
module uart_fifo_tx #(
    parameter int DATA_WIDTH  = 8,
    parameter int PRESC_WIDTH = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [PRESC_WIDTH-1:0] PRESCALE,
    input  logic                   PAR_EN,
    input  logic                   PAR_TYP,
    input  logic                   FIFO_EMPTY,
    input  logic [DATA_WIDTH-1:0]  FIFO_RD_DATA,
    output logic                   FIFO_R_INC,
    output logic                   TX_OUT,
    output logic                   BUSY
);
    import uart_tx_pkg::*;
    localparam int IW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IW-1:0] LAST = IW'(DATA_WIDTH - 1);
    state_e                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  shreg_q, shreg_d;
    logic [PRESC_WIDTH-1:0] presc_q, presc_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic                   par_en_q, par_en_d, par_q, par_d, tx_q, tx_d, bit_done;
    assign FIFO_R_INC = state_q == IDLE && !FIFO_EMPTY && !RST;
    assign TX_OUT = tx_q;
    assign BUSY = state_q != IDLE;
    uart_tx_bit_timer #(.PRESC_WIDTH(PRESC_WIDTH)) u_timer (
        .CLK        (CLK),
        .RST        (RST),
        .clear_i    (state_q == IDLE),
        .presc_i    (presc_q),
        .bit_done_o (bit_done)
    );
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        presc_d  = presc_q;
        idx_d    = idx_q;
        par_en_d = par_en_q;
        par_d    = par_q;
        case (state_q)
            IDLE: if (FIFO_R_INC) begin
                state_d  = START;
                shreg_d  = FIFO_RD_DATA;
                presc_d  = PRESCALE == '0 ? PRESC_WIDTH'(1) : PRESCALE;
                par_en_d = PAR_EN;
                par_d    = ^FIFO_RD_DATA ^ (PAR_TYP == PAR_ODD);
            end
            START: if (bit_done) begin
                state_d = DATA;
                idx_d   = '0;
            end
            DATA: if (bit_done) begin
                shreg_d = shreg_q >> 1;
                idx_d   = idx_q + IW'(1);
                if (idx_q == LAST) state_d = par_en_q ? PARITY : STOP;
            end
            PARITY: if (bit_done) state_d = STOP;
            STOP: if (bit_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // TX_OUT is registered, so drive the level belonging to the state being entered.
        tx_d = state_d == START ? 1'b0 : state_d == DATA ? shreg_d[0] : state_d == PARITY ? par_d : LINE_IDLE;
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            presc_q  <= PRESC_WIDTH'(1);
            idx_q    <= '0;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
            tx_q     <= LINE_IDLE;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            par_en_q <= par_en_d;
            par_q    <= par_d;
            tx_q     <= tx_d;
        end
    end
endmodule

// File: tb/tb_uart_fifo_tx.sv
// tb_uart_fifo_tx: directed bench with a per-cycle frame-queue model of the UART TX FIFO reader.
module tb_uart_fifo_tx;
    logic        CLK = 1'b0, RST = 1'b1;
    logic [15:0] PRESCALE = 16'd4;
    logic        PAR_EN = 1'b0, PAR_TYP = 1'b0;
    logic        FIFO_EMPTY = 1'b1;
    logic [7:0]  FIFO_RD_DATA = 8'h00;
    logic        FIFO_R_INC, TX_OUT, BUSY;
    int errors = 0, checks = 0, cyc = 0;
    int rinc_cnt = 0, last_rinc = 0, rinc_gap = 0, busy_cyc = 0, txlow_cyc = 0;
    logic       mq[$];
    logic [7:0] fq[$], push_q[$];
    always #5 CLK = ~CLK;
    uart_fifo_tx #(.DATA_WIDTH(8), .PRESC_WIDTH(16)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .PRESCALE     (PRESCALE),
        .PAR_EN       (PAR_EN),
        .PAR_TYP      (PAR_TYP),
        .FIFO_EMPTY   (FIFO_EMPTY),
        .FIFO_RD_DATA (FIFO_RD_DATA),
        .FIFO_R_INC   (FIFO_R_INC),
        .TX_OUT       (TX_OUT),
        .BUSY         (BUSY)
    );
    // Expected line level for every cycle of a frame: start, data LSB first, optional parity, stop.
    task automatic add_frame(input logic [7:0] d);
        int p;
        logic [10:0] b;
        p = PRESCALE == 16'd0 ? 1 : int'(PRESCALE);
        b = {1'b1, PAR_TYP ? ~^d : ^d, d, 1'b0};
        for (int i = 0; i < 11; i++)
            if (i != 9 || PAR_EN)
                repeat (p) mq.push_back(b[i]);
    endtask
    // Model + FIFO: a pop happens whenever the line model is idle and data is present.
    always @(posedge CLK) begin
        if (RST) mq.delete();
        else if (mq.size() != 0) void'(mq.pop_front());
        else if (!FIFO_EMPTY) begin
            add_frame(FIFO_RD_DATA);
            void'(fq.pop_front());
        end
        while (push_q.size() != 0) fq.push_back(push_q.pop_front());
        FIFO_EMPTY   <= fq.size() == 0;
        FIFO_RD_DATA <= fq.size() != 0 ? fq[0] : 8'h00;
    end
    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask
    task automatic tick();
        @(negedge CLK);
        cyc++;
        chk("tx_out", TX_OUT, mq.size() != 0 ? mq[0] : 1'b1);
        chk("busy", BUSY, mq.size() != 0);
        chk("r_inc", FIFO_R_INC, mq.size() == 0 && !FIFO_EMPTY && !RST);
        if (FIFO_R_INC === 1'b1) begin
            rinc_cnt++;
            rinc_gap = cyc - last_rinc;
            last_rinc = cyc;
        end
        if (BUSY === 1'b1) busy_cyc++;
        if (TX_OUT === 1'b0) txlow_cyc++;
    endtask
    task automatic wait_busy();
        int w = 0;
        while (BUSY !== 1'b1 && w < 400) begin
            tick();
            w++;
        end
        chk("busy_seen", BUSY, 1'b1);
    endtask
    task automatic run_frame(input int p, input int new_p, output logic [15:0] bits, output int blen);
        bits = '0;
        blen = 0;
        wait_busy();
        if (new_p >= 0) PRESCALE = 16'(new_p);
        while (BUSY === 1'b1 && blen < 2000) begin
            if (blen % p == 0 && blen / p < 16) bits[blen / p] = TX_OUT;
            blen++;
            tick();
        end
    endtask
    initial begin
        logic [15:0] bits;
        int blen, r0, b0, t0;
        repeat (3) tick();
        chk("rst_tx", TX_OUT, 1'b1);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_rinc", FIFO_R_INC, 1'b0);
        RST = 1'b0;
        tick();
        r0 = rinc_cnt;
        push_q.push_back(8'hA5);
        run_frame(4, -1, bits, blen);
        chk("basic_bits", bits[9:0], 10'h34A);
        chk("basic_len", blen, 40);
        chk("basic_pops", rinc_cnt - r0, 1);
        PAR_EN = 1'b1;
        push_q.push_back(8'hA5);
        run_frame(4, -1, bits, blen);
        chk("even_len", blen, 44);
        chk("even_par", bits[9], 1'b0);
        PAR_TYP = 1'b1;
        push_q.push_back(8'hA5);
        run_frame(4, -1, bits, blen);
        chk("odd_par", bits[9], 1'b1);
        chk("odd_stop", bits[10], 1'b1);
        PAR_TYP = 1'b0;
        push_q.push_back(8'h01);
        run_frame(4, -1, bits, blen);
        chk("even01_par", bits[9], 1'b1);
        PAR_EN = 1'b0;
        PRESCALE = 16'd1;
        r0 = rinc_cnt;
        push_q.push_back(8'h00);
        push_q.push_back(8'hFF);
        run_frame(1, -1, bits, blen);
        chk("b2b_bits0", bits[9:0], 10'h200);
        chk("b2b_len0", blen, 10);
        run_frame(1, -1, bits, blen);
        chk("b2b_bits1", bits[9:0], 10'h3FE);
        chk("b2b_pops", rinc_cnt - r0, 2);
        chk("b2b_gap", rinc_gap, 11);
        PRESCALE = 16'd0;
        push_q.push_back(8'h5A);
        run_frame(1, -1, bits, blen);
        chk("presc0_len", blen, 10);
        PRESCALE = 16'd4;
        push_q.push_back(8'h12);
        push_q.push_back(8'h34);
        run_frame(4, 8, bits, blen);
        chk("presc_keep_len", blen, 40);
        run_frame(8, -1, bits, blen);
        chk("presc_next_len", blen, 80);
        PRESCALE = 16'd4;
        push_q.push_back(8'hA5);
        wait_busy();
        repeat (17) tick();
        push_q.push_back(8'h3C);
        RST = 1'b1;
        tick();
        chk("midrst_tx", TX_OUT, 1'b1);
        chk("midrst_busy", BUSY, 1'b0);
        chk("midrst_rinc", FIFO_R_INC, 1'b0);
        repeat (2) tick();
        chk("rst_hold_rinc", FIFO_R_INC, 1'b0);
        RST = 1'b0;
        #1;
        chk("pop_after_rst", FIFO_R_INC, 1'b1);
        run_frame(4, -1, bits, blen);
        chk("after_rst_bits", bits[9:0], 10'h278);
        chk("after_rst_len", blen, 40);
        r0 = rinc_cnt;
        b0 = busy_cyc;
        t0 = txlow_cyc;
        repeat (100) tick();
        chk("empty_pops", rinc_cnt - r0, 0);
        chk("empty_busy", busy_cyc - b0, 0);
        chk("empty_txlow", txlow_cyc - t0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
